// File: rtl/conv_mac_pkg.sv
// Shared definitions for the convolution MAC execute stage.
// Holds default widths, opcode encodings and the control FSM state encoding.
package conv_mac_pkg;

    localparam int unsigned WIDTH_DEF      = 32;
    localparam int unsigned REG_ADDR_W_DEF = 5;

    typedef enum logic [1:0] {
        OP_MAC   = 2'b00,
        OP_MUL   = 2'b01,
        OP_LDACC = 2'b10,
        OP_RDACC = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StMul  = 3'd1,
        StAcc  = 3'd2,
        StWb   = 3'd3,
        StLd   = 3'd4
    } state_e;

endpackage

// File: rtl/conv_mac_unit_seq_multiplier.sv
// Radix-2 shift-add multiplier, one multiplier bit per clock, LSB first.
// Ports:
//   clock, reset      - rising-edge clock, synchronous active-high reset
//   start             - load operands, clear product and bit counter
//   multiplicand      - operand shifted left each step
//   multiplier        - operand whose bits are consumed LSB first
//   product           - low WIDTH bits of multiplicand*multiplier
//   valid             - high during the final step; product is final after that edge
module seq_multiplier #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] multiplicand,
    input  logic [WIDTH-1:0] multiplier,
    output logic [WIDTH-1:0] product,
    output logic             valid
);

    localparam int unsigned CntW = $clog2(WIDTH);
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    logic [WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0] mplier_q;
    logic [WIDTH-1:0] product_q;
    logic [CntW-1:0]  count_q;
    logic             running_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            mcand_q   <= '0;
            mplier_q  <= '0;
            product_q <= '0;
            count_q   <= '0;
            running_q <= 1'b0;
        end else if (start) begin
            mcand_q   <= multiplicand;
            mplier_q  <= multiplier;
            product_q <= '0;
            count_q   <= '0;
            running_q <= 1'b1;
        end else if (running_q) begin
            // Modular add: bits shifted past WIDTH fall off, giving the low half only.
            if (mplier_q[0]) begin
                product_q <= product_q + mcand_q;
            end
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            count_q  <= count_q + 1'b1;
            if (count_q == LastCnt) begin
                running_q <= 1'b0;
            end
        end
    end

    assign product = product_q;
    assign valid   = running_q && (count_q == LastCnt);

endmodule

// File: rtl/conv_mac_unit.sv
// Multi-cycle multiply-accumulate execute stage for the convolution datapath.
// Operands come from the register-file read ports; results go back through the
// write port. One internal accumulator holds running convolution sums.
// Ports:
//   clock, reset            - rising-edge clock, synchronous active-high reset
//   start, op               - request and opcode (MAC/MUL/LDACC/RDACC), sampled in IDLE
//   operand_a, operand_b    - rs1/rs2 values
//   rd_in                   - destination register number
//   busy                    - high whenever not IDLE
//   done                    - one-cycle completion pulse
//   write_reg, write_data, regwrite - register-file write port
//   acc_out                 - registered accumulator, for debug
module conv_mac_unit
    import conv_mac_pkg::*;
#(
    parameter int unsigned WIDTH      = WIDTH_DEF,
    parameter int unsigned REG_ADDR_W = REG_ADDR_W_DEF
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [1:0]            op,
    input  logic [WIDTH-1:0]      operand_a,
    input  logic [WIDTH-1:0]      operand_b,
    input  logic [REG_ADDR_W-1:0] rd_in,
    output logic                  busy,
    output logic                  done,
    output logic [REG_ADDR_W-1:0] write_reg,
    output logic [WIDTH-1:0]      write_data,
    output logic                  regwrite,
    output logic [WIDTH-1:0]      acc_out
);

    state_e                state_q;
    op_e                   op_q;
    logic [WIDTH-1:0]      a_q;
    logic [REG_ADDR_W-1:0] rd_q;
    logic [WIDTH-1:0]      acc_q;

    logic [WIDTH-1:0]      product;
    logic                  mul_valid;
    logic                  mul_start;

    // Multiplier loads its operands on the same edge the FSM enters StMul.
    assign mul_start = (state_q == StIdle) && start &&
                       ((op_e'(op) == OP_MAC) || (op_e'(op) == OP_MUL));

    seq_multiplier #(
        .WIDTH(WIDTH)
    ) u_mul (
        .clock        (clock),
        .reset        (reset),
        .start        (mul_start),
        .multiplicand (operand_a),
        .multiplier   (operand_b),
        .product      (product),
        .valid        (mul_valid)
    );

    // done/regwrite/write_* are registered on the edge entering WB or LD so they
    // are valid for exactly that one cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= StIdle;
            op_q       <= OP_MAC;
            a_q        <= '0;
            rd_q       <= '0;
            acc_q      <= '0;
            done       <= 1'b0;
            regwrite   <= 1'b0;
            write_reg  <= '0;
            write_data <= '0;
        end else begin
            done     <= 1'b0;
            regwrite <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        op_q <= op_e'(op);
                        a_q  <= operand_a;
                        rd_q <= rd_in;
                        unique case (op_e'(op))
                            OP_MAC, OP_MUL: state_q <= StMul;
                            OP_LDACC: begin
                                done    <= 1'b1;
                                state_q <= StLd;
                            end
                            OP_RDACC: begin
                                write_reg  <= rd_in;
                                write_data <= acc_q;
                                regwrite   <= (rd_in != '0);
                                done       <= 1'b1;
                                state_q    <= StWb;
                            end
                        endcase
                    end
                end
                StMul: begin
                    if (mul_valid) begin
                        state_q <= StAcc;
                    end
                end
                StAcc: begin
                    if (op_q == OP_MAC) begin
                        acc_q      <= acc_q + product;
                        write_data <= acc_q + product;
                    end else begin
                        write_data <= product;
                    end
                    write_reg <= rd_q;
                    regwrite  <= (rd_q != '0);
                    done      <= 1'b1;
                    state_q   <= StWb;
                end
                StWb: state_q <= StIdle;
                StLd: begin
                    acc_q   <= a_q;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy    = (state_q != StIdle);
    assign acc_out = acc_q;

endmodule

// File: tb/tb_conv_mac_unit.sv
module tb_conv_mac_unit;

    logic        clock;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic [4:0]  rd_in;
    logic        busy;
    logic        done;
    logic [4:0]  write_reg;
    logic [31:0] write_data;
    logic        regwrite;
    logic [31:0] acc_out;

    int n_checks = 0;
    int n_bad    = 0;

    conv_mac_unit #(
        .WIDTH      (32),
        .REG_ADDR_W (5)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .op         (op),
        .operand_a  (operand_a),
        .operand_b  (operand_b),
        .rd_in      (rd_in),
        .busy       (busy),
        .done       (done),
        .write_reg  (write_reg),
        .write_data (write_data),
        .regwrite   (regwrite),
        .acc_out    (acc_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Issue one op, optionally pulse start (with scrambled operands) at cycles p1/p2,
    // then check latency, busy duration and the writeback outputs of the done cycle.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd, input int exp_lat,
                          input logic exp_rw, input logic [31:0] exp_wd, input int p1,
                          input int p2);
        int   lat = 0;
        int   busy_cnt = 0;
        int   extra = 0;
        logic found = 1'b0;
        logic       got_rw = 1'b0;
        logic [4:0] got_wr = '0;
        logic [31:0] got_wd = '0;
        @(negedge clock);
        start = 1'b1; op = o; operand_a = a; operand_b = b; rd_in = rd;
        @(negedge clock);
        for (int c = 1; c <= 100; c++) begin
            if (c == p1 || c == p2) begin
                start = 1'b1; op = 2'b01;
                operand_a = 32'h1234_5678; operand_b = 32'h0000_0FFF; rd_in = 5'd17;
            end else begin
                start = 1'b0;
            end
            if (busy) busy_cnt++;
            if (done) begin
                found = 1'b1; lat = c;
                got_rw = regwrite; got_wr = write_reg; got_wd = write_data;
                break;
            end
            @(negedge clock);
        end
        start = 1'b0;
        if (!found) begin
            check_eq({tag, "_timeout"}, 32'd0, 32'd1);
        end else begin
            check_eq({tag, "_lat"}, lat, exp_lat);
            check_eq({tag, "_busycnt"}, busy_cnt, exp_lat);
            check_eq({tag, "_regwrite"}, {31'd0, got_rw}, {31'd0, exp_rw});
            if (exp_rw) begin
                check_eq({tag, "_wreg"}, {27'd0, got_wr}, {27'd0, rd});
                check_eq({tag, "_wdata"}, got_wd, exp_wd);
            end
            @(negedge clock);
            check_eq({tag, "_idle_after"}, {31'd0, busy}, 32'd0);
            for (int k = 0; k < 4; k++) begin
                if (done || regwrite) extra++;
                @(negedge clock);
            end
            check_eq({tag, "_no_extra"}, extra, 0);
        end
    endtask

    initial begin
        int bad_idle;
        reset = 1'b1; start = 1'b0; op = 2'b00;
        operand_a = '0; operand_b = '0; rd_in = '0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_done", {31'd0, done}, 32'd0);
        check_eq("rst_regwrite", {31'd0, regwrite}, 32'd0);
        check_eq("rst_wreg", {27'd0, write_reg}, 32'd0);
        check_eq("rst_wdata", write_data, 32'd0);
        check_eq("rst_acc", acc_out, 32'd0);
        bad_idle = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (busy || regwrite) bad_idle++;
        end
        check_eq("idle_10", bad_idle, 0);

        run_op("mul7x6", 2'b01, 32'd7, 32'd6, 5'd5, 34, 1'b1, 32'd42, 0, 0);
        check_eq("mul7x6_acc", acc_out, 32'd0);

        run_op("ldacc", 2'b10, 32'hFFFF_FFF0, 32'd0, 5'd0, 1, 1'b0, 32'd0, 0, 0);
        check_eq("ldacc_acc", acc_out, 32'hFFFF_FFF0);
        run_op("mac_wrap", 2'b00, 32'd4, 32'd5, 5'd9, 34, 1'b1, 32'h0000_0004, 0, 0);
        check_eq("mac_wrap_acc", acc_out, 32'h0000_0004);
        run_op("rdacc", 2'b11, 32'd0, 32'd0, 5'd3, 1, 1'b1, 32'd4, 0, 0);

        run_op("mul_neg3x5", 2'b01, 32'hFFFF_FFFD, 32'd5, 5'd1, 34, 1'b1, 32'hFFFF_FFF1, 0, 0);
        run_op("mul_min_x2", 2'b01, 32'h8000_0000, 32'd2, 5'd2, 34, 1'b1, 32'h0000_0000, 0, 0);
        check_eq("signed_acc_kept", acc_out, 32'd4);

        // 4 + 2*3 = 10; start pulses at cycles 5 and 20 must be ignored.
        run_op("mac_protect", 2'b00, 32'd2, 32'd3, 5'd10, 34, 1'b1, 32'd10, 5, 20);
        check_eq("mac_protect_acc", acc_out, 32'd10);
        run_op("mul_rd0", 2'b01, 32'd2, 32'd2, 5'd0, 34, 1'b0, 32'd0, 0, 0);

        // Reset in cycle 15 of a MAC.
        @(negedge clock);
        start = 1'b1; op = 2'b00; operand_a = 32'd5; operand_b = 32'd5; rd_in = 5'd12;
        @(negedge clock);
        start = 1'b0;
        repeat (14) @(negedge clock);
        check_eq("midrst_busy_before", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check_eq("midrst_busy", {31'd0, busy}, 32'd0);
        check_eq("midrst_acc", acc_out, 32'd0);
        check_eq("midrst_wdata", write_data, 32'd0);
        bad_idle = 0;
        for (int i = 0; i < 40; i++) begin
            if (regwrite || done || busy) bad_idle++;
            @(negedge clock);
        end
        check_eq("midrst_no_write", bad_idle, 0);
        run_op("mul3x3", 2'b01, 32'd3, 32'd3, 5'd7, 34, 1'b1, 32'd9, 0, 0);
        check_eq("mul3x3_acc", acc_out, 32'd0);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
